riscv_trace_buffer: RTL and testbench
=====================================

Name: riscv_trace_buffer

Overview:
- Sits directly downstream of the riscv core's debug/trace outputs: reg_write_sig/reg_num/reg_data and wr/rd/addr/wr_data/rd_data.
- Captures register write-backs and data-memory accesses as timestamped entries in a FIFO.
- Drains entries through a valid/ready port to a log sink (UART framer or sim dumper), so the core can be traced on silicon without $display.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4.
- TS_W, 16, timestamp width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- enable  in  1  capture enable
- clr_stats  in  1  clears drop_count, overflow, protocol_err
- reg_write_sig  in  1  core register write strobe
- reg_num  in  5  destination register
- reg_data  in  32  write-back value
- wr  in  1  data-memory write strobe
- rd  in  1  data-memory read strobe
- addr  in  9  data-memory address
- wr_data  in  32  store data
- rd_data  in  32  load data
- out_valid  out  1  head entry valid
- out_ready  in  1  sink accepts head entry
- out_type  out  2  0 = reg write, 1 = mem write, 2 = mem read (3 is never produced)
- out_idx  out  9  reg_num zero-extended, or addr
- out_data  out  32  reg_data, wr_data or rd_data
- out_time  out  TS_W  timestamp of capture cycle
- level  out  $clog2(DEPTH)+1  occupied entries
- drop_count  out  16  saturating count of dropped events
- overflow  out  1  sticky: at least one drop
- protocol_err  out  1  sticky: wr and rd asserted in the same cycle

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; out_valid=0, level=0.
  - out_type/out_idx/out_data/out_time = 0.
  - drop_count=0, overflow=0, protocol_err=0, timestamp counter=0.
  - Reset asserted mid-drain discards all entries immediately.
- Timestamp counter:
  - Increments every clk after reset release, independent of enable.
  - Wraps modulo 2^TS_W.
  - An entry carries the counter value of the cycle its inputs were sampled.
- Events, sampled at posedge clk when enable=1:
  - Reg event: reg_write_sig=1 and reg_num!=0. A write to x0 is never recorded.
  - Mem event: wr=1 gives type 1 with wr_data. rd=1 and wr=0 gives type 2 with rd_data.
  - wr=1 and rd=1 together: record the write only; set protocol_err.
- Push rules:
  - At most two pushes per cycle: reg event first, then mem event, occupying consecutive slots in that order.
  - Free space = DEPTH - level at the start of the cycle. A pop in the same cycle does not add space.
  - Events that do not fit are dropped in priority order: the mem event is dropped before the reg event.
  - Each dropped event increments drop_count (saturates at 16'hFFFF) and sets overflow.
- enable=0: no captures, no drops; draining continues.
- Output port:
  - out_valid=1 the cycle after the first entry is written into an empty FIFO (1-cycle latency). Entries are registered at the head.
  - Pop on out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
  - Strict FIFO order.
- level:
  - Registered.
  - Reflects all pushes and pops of the previous edge.
  - Never exceeds DEPTH.
- clr_stats:
  - Clears drop_count, overflow and protocol_err; the FIFO is untouched.
  - If a drop or protocol error occurs in the same cycle, clear applies first, then the new event. Example: one drop gives drop_count=1, overflow=1.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. The full/empty distinction comes from a count register, not from pointer equality.

Test Plan:
- Reset release, one cycle reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF at ts=3, out_ready=1 -> next cycle out_valid=1, out_type=0, out_idx=5, out_data=DEADBEEF, out_time=3; level returns to 0 after the pop.
- Same cycle reg write x2=7 and wr=1, addr=9'd40, wr_data=32'h11 -> two entries in order: (0,2,7) then (1,40,0x11); level=2 with out_ready=0.
- reg_write_sig=1 with reg_num=0, and also enable=0 with wr=1 -> no entries, level stays 0, drop_count stays 0.
- DEPTH=16, out_ready=0, 15 reg writes, then one cycle with reg write + mem read -> reg entry accepted, level=16, drop_count=1, overflow=1; a further 2 events -> drop_count=3; assert clr_stats -> drop_count=0, overflow=0, level still 16.
- wr=1 and rd=1, addr=12 -> single type-1 entry, protocol_err=1; stall out_ready=0 for 5 cycles -> out_* unchanged; out_ready=1 -> pop.
- 8 entries buffered, assert reset low mid-cycle -> out_valid, level, drop_count go to 0 immediately without a clock edge; after release the timestamp restarts at 0.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: captures register write-backs and data-memory accesses
// from the core's trace outputs as timestamped entries. The entries are held
// in a FIFO and drained to a log sink through a valid/ready port.
module riscv_trace_buffer #(
  parameter int DEPTH = 16,  // FIFO entries, power of two, >= 4
  parameter int TS_W  = 16   // timestamp width
) (
  input  logic                     clk,
  input  logic                     reset,          // async, active-low
  input  logic                     enable,
  input  logic                     clr_stats,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [31:0]              reg_data,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [8:0]               addr,
  input  logic [31:0]              wr_data,
  input  logic [31:0]              rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_type,
  output logic [8:0]               out_idx,
  output logic [31:0]              out_data,
  output logic [TS_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count,
  output logic                     overflow,
  output logic                     protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    EV_REG    = 2'd0,
    EV_MEM_WR = 2'd1,
    EV_MEM_RD = 2'd2
  } ev_type_e;

  typedef struct packed {
    logic [1:0]      typ;
    logic [8:0]      idx;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nx;
  logic [LW-1:0]   count_q, count_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [15:0]     drop_q, drop_d;
  logic            ovf_q, ovf_d, perr_q, perr_d;

  logic            reg_ev, mem_ev, pop;
  logic [1:0]      n_ev, n_push, n_drop;
  logic [LW-1:0]   free;
  entry_t          reg_ent, mem_ent, slot0, slot1, head;
  logic [15:0]     drop_base;
  logic [16:0]     drop_sum;
  logic            ovf_base, perr_base;

  // Event decode, push/drop arbitration, pointer/count and statistics update.
  always_comb begin
    reg_ev  = enable && reg_write_sig && (reg_num != 5'd0);
    mem_ev  = enable && (wr || rd);

    reg_ent = '{typ: EV_REG, idx: {4'd0, reg_num}, data: reg_data, ts: ts_q};
    if (wr) mem_ent = '{typ: EV_MEM_WR, idx: addr, data: wr_data, ts: ts_q};
    else    mem_ent = '{typ: EV_MEM_RD, idx: addr, data: rd_data, ts: ts_q};

    // Reg event takes the first slot; the mem event follows it.
    slot0 = reg_ev ? reg_ent : mem_ent;
    slot1 = mem_ent;

    // Space is judged at the start of the cycle; a same-cycle pop does not help.
    free = DEPTH_L - count_q;
    n_ev = {1'b0, reg_ev} + {1'b0, mem_ev};
    if (free >= LW'(n_ev)) n_push = n_ev;
    else                   n_push = free[1:0];  // free is 0 or 1 here
    n_drop = n_ev - n_push;

    pop       = (count_q != '0) && out_ready;
    count_d   = count_q + LW'(n_push) - LW'(pop);
    wr_ptr_nx = wr_ptr_q + AW'(1);
    wr_ptr_d  = wr_ptr_q + AW'(n_push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    ts_d      = ts_q + TS_W'(1);

    // Clear is applied first, then this cycle's drops and protocol errors.
    drop_base = clr_stats ? 16'd0 : drop_q;
    ovf_base  = clr_stats ? 1'b0  : ovf_q;
    perr_base = clr_stats ? 1'b0  : perr_q;
    drop_sum  = {1'b0, drop_base} + 17'(n_drop);
    drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d     = ovf_base | (n_drop != 2'd0);
    perr_d    = perr_base | (enable && wr && rd);
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ts_q     <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ts_q     <= ts_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; a slot is only read after it was written,
  // and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem_q[wr_ptr_q]  <= slot0;
    if (n_push == 2'd2) mem_q[wr_ptr_nx] <= slot1;
  end

  // Head presentation: zero whenever there is nothing to deliver.
  always_comb begin
    head = '0;
    if (count_q != '0) head = mem_q[rd_ptr_q];
  end

  assign out_valid    = (count_q != '0);
  assign out_type     = head.typ;
  assign out_idx      = head.idx;
  assign out_data     = head.data;
  assign out_time     = head.ts;
  assign level        = count_q;
  assign drop_count   = drop_q;
  assign overflow     = ovf_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Testbench for riscv_trace_buffer: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the trace FIFO.
module tb_riscv_trace_buffer;

  localparam int DEPTH = 16;
  localparam int TS_W  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, clr_stats, reg_write_sig, wr, rd, out_ready;
  logic [4:0]  reg_num;
  logic [31:0] reg_data, wr_data, rd_data;
  logic [8:0]  addr;
  logic        out_valid, overflow, protocol_err;
  logic [1:0]  out_type;
  logic [8:0]  out_idx;
  logic [31:0] out_data;
  logic [TS_W-1:0] out_time;
  logic [4:0]  level;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  riscv_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr_stats(clr_stats),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_idx(out_idx), .out_data(out_data), .out_time(out_time),
    .level(level), .drop_count(drop_count), .overflow(overflow),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]      typ;
    logic [8:0]      idx;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } ent_t;

  ent_t mq[$];
  int   m_ts, m_drop;
  bit   m_ovf, m_perr;

  function automatic void model_clear();
    mq.delete();
    m_ts = 0; m_drop = 0; m_ovf = 0; m_perr = 0;
  endfunction

  // One clock edge of behaviour, from the current inputs and model state.
  function automatic void model_step();
    ent_t ev[$];
    ent_t e;
    int   space = DEPTH - mq.size();
    int   drops = 0;
    bit   do_pop = (mq.size() > 0) && out_ready;
    if (enable) begin
      if (reg_write_sig && reg_num != 0) begin
        e.typ = 2'd0; e.idx = {4'd0, reg_num}; e.data = reg_data; e.ts = TS_W'(m_ts);
        ev.push_back(e);
      end
      if (wr || rd) begin
        e.typ = wr ? 2'd1 : 2'd2; e.idx = addr; e.data = wr ? wr_data : rd_data;
        e.ts = TS_W'(m_ts);
        ev.push_back(e);
      end
    end
    if (do_pop) void'(mq.pop_front());
    foreach (ev[i]) begin
      if (space > 0) begin mq.push_back(ev[i]); space--; end
      else drops++;
    end
    if (clr_stats) begin m_drop = 0; m_ovf = 0; m_perr = 0; end
    m_drop = (m_drop + drops > 16'hFFFF) ? 16'hFFFF : m_drop + drops;
    if (drops > 0) m_ovf = 1;
    if (enable && wr && rd) m_perr = 1;
    m_ts = (m_ts + 1) % (1 << TS_W);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    enable = 1'b1; clr_stats = 1'b0; reg_write_sig = 1'b0; reg_num = '0;
    reg_data = '0; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if ({out_type, out_idx, out_data, out_time} !== '0) begin errors++;
      $display("FAIL reset_out got %0d/%0d/%h/%0d exp zeros", out_type, out_idx, out_data, out_time); end
    checks++; if ({drop_count, overflow, protocol_err} !== '0) begin errors++;
      $display("FAIL reset_stats got %0d/%0b/%0b exp 0/0/0", drop_count, overflow, protocol_err); end
  endtask

  task automatic test_single_reg();
    idle_inputs(); out_ready = 1'b1;
    repeat (3) cycle();                       // timestamps 0,1,2 pass idle
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    checks++; if (out_valid !== 1'b1 || level !== 5'd1) begin errors++;
      $display("FAIL single_valid got v=%0b l=%0d exp v=1 l=1", out_valid, level); end
    checks++; if (out_type !== 2'd0 || out_idx !== 9'd5 || out_data !== 32'hDEADBEEF || out_time !== 16'd3) begin errors++;
      $display("FAIL single_entry got %0d/%0d/%h/%0d exp 0/5/deadbeef/3", out_type, out_idx, out_data, out_time); end
    cycle();
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL single_pop got l=%0d v=%0b exp l=0 v=0", level, out_valid); end
  endtask

  task automatic test_dual_push();
    idle_inputs(); out_ready = 1'b0;
    reg_write_sig = 1'b1; reg_num = 5'd2; reg_data = 32'd7;
    wr = 1'b1; addr = 9'd40; wr_data = 32'h11;
    cycle();
    idle_inputs();
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL dual_level got %0d exp 2", level); end
    checks++; if (out_type !== 2'd0 || out_idx !== 9'd2 || out_data !== 32'd7) begin errors++;
      $display("FAIL dual_first got %0d/%0d/%h exp 0/2/7", out_type, out_idx, out_data); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_type !== 2'd1 || out_idx !== 9'd40 || out_data !== 32'h11 || level !== 5'd1) begin errors++;
      $display("FAIL dual_second got %0d/%0d/%h l=%0d exp 1/40/11 l=1", out_type, out_idx, out_data, level); end
    cycle();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL dual_drain got %0d exp 0", level); end
  endtask

  task automatic test_filtered();
    idle_inputs(); out_ready = 1'b0;
    reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h1234;
    cycle();
    idle_inputs(); enable = 1'b0; wr = 1'b1; addr = 9'd3; wr_data = 32'h55;
    cycle();
    idle_inputs();
    checks++; if (level !== 5'd0 || out_valid !== 1'b0 || drop_count !== 16'd0) begin errors++;
      $display("FAIL filtered got l=%0d v=%0b d=%0d exp 0/0/0", level, out_valid, drop_count); end
  endtask

  task automatic test_overflow();
    idle_inputs(); out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'($urandom_range(1, 31)); reg_data = $urandom;
      cycle();
    end
    reg_num = 5'd9; reg_data = 32'hA5A5; rd = 1'b1; addr = 9'd100; rd_data = 32'hBEEF;
    cycle();
    checks++; if (level !== 5'd16 || drop_count !== 16'd1 || overflow !== 1'b1) begin errors++;
      $display("FAIL full_drop got l=%0d d=%0d o=%0b exp 16/1/1", level, drop_count, overflow); end
    idle_inputs(); reg_write_sig = 1'b1; reg_num = 5'd3;
    repeat (2) cycle();
    idle_inputs();
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL full_drop3 got %0d exp 3", drop_count); end
    clr_stats = 1'b1;
    cycle();
    checks++; if (drop_count !== 16'd0 || overflow !== 1'b0 || level !== 5'd16) begin errors++;
      $display("FAIL clr_stats got d=%0d o=%0b l=%0d exp 0/0/16", drop_count, overflow, level); end
    wr = 1'b1; addr = 9'd1;             // clear together with a new drop
    cycle();
    idle_inputs();
    checks++; if (drop_count !== 16'd1 || overflow !== 1'b1 || protocol_err !== 1'b0) begin errors++;
      $display("FAIL clr_and_drop got d=%0d o=%0b p=%0b exp 1/1/0", drop_count, overflow, protocol_err); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ent_t e = mq[0];
      checks++; if (out_valid !== 1'b1 || out_type !== e.typ || out_idx !== e.idx || out_data !== e.data || out_time !== e.ts) begin errors++;
        $display("FAIL drain_order[%0d] got %0b %0d/%0d/%h/%0d exp 1 %0d/%0d/%h/%0d", i, out_valid,
                 out_type, out_idx, out_data, out_time, e.typ, e.idx, e.data, e.ts); end
      cycle();
    end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_empty got %0d exp 0", level); end
    clr_stats = 1'b1; cycle(); clr_stats = 1'b0;
  endtask

  task automatic test_protocol();
    logic [15:0] t0;
    idle_inputs(); out_ready = 1'b0;
    wr = 1'b1; rd = 1'b1; addr = 9'd12; wr_data = 32'hCAFE0001; rd_data = 32'h0BAD0BAD;
    t0 = TS_W'(m_ts);
    cycle();
    idle_inputs();
    checks++; if (level !== 5'd1 || protocol_err !== 1'b1) begin errors++;
      $display("FAIL perr_entry got l=%0d p=%0b exp 1/1", level, protocol_err); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_type !== 2'd1 || out_idx !== 9'd12 || out_data !== 32'hCAFE0001 || out_time !== t0) begin errors++;
        $display("FAIL stall_hold[%0d] got %0b %0d/%0d/%h/%0d exp 1 1/12/cafe0001/%0d", i, out_valid,
                 out_type, out_idx, out_data, out_time, t0); end
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL stall_pop got l=%0d v=%0b exp 0/0", level, out_valid); end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i + 1); reg_data = 32'(i);
      cycle();
    end
    idle_inputs();
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL mid_fill got %0d exp 8", level); end
    out_ready = 1'b1;
    #1 reset = 1'b0;                     // between edges
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0 || drop_count !== 16'd0 || protocol_err !== 1'b0) begin errors++;
      $display("FAIL mid_reset got v=%0b l=%0d d=%0d p=%0b exp 0/0/0/0", out_valid, level, drop_count, protocol_err); end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle();
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h77;
    out_ready = 1'b0;
    cycle();
    idle_inputs();
    checks++; if (out_valid !== 1'b1 || out_time !== 16'd2) begin errors++;
      $display("FAIL ts_restart got v=%0b t=%0d exp 1/2", out_valid, out_time); end
    out_ready = 1'b1; cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      ent_t e;
      bit   ev;
      int   bias = (c / 500) % 3;        // alternate drain pressure
      enable        = ($urandom_range(0, 9) != 0);
      clr_stats     = ($urandom_range(0, 49) == 0);
      reg_write_sig = $urandom_range(0, 1);
      reg_num       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      reg_data      = $urandom;
      wr            = ($urandom_range(0, 2) == 0);
      rd            = ($urandom_range(0, 2) == 0);
      addr          = 9'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      out_ready     = (bias == 0) ? ($urandom_range(0, 3) == 0)
                    : (bias == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      cycle();
      ev = (mq.size() > 0);
      if (ev) e = mq[0];
      else begin e.typ = '0; e.idx = '0; e.data = '0; e.ts = '0; end
      checks++; if (out_valid !== ev || level !== 5'(mq.size())) begin errors++;
        $display("FAIL rand_level cyc %0d got v=%0b l=%0d exp v=%0b l=%0d", c, out_valid, level, ev, mq.size()); end
      checks++; if (out_type !== e.typ || out_idx !== e.idx || out_data !== e.data || out_time !== e.ts) begin errors++;
        $display("FAIL rand_head cyc %0d got %0d/%0d/%h/%0d exp %0d/%0d/%h/%0d", c, out_type, out_idx,
                 out_data, out_time, e.typ, e.idx, e.data, e.ts); end
      checks++; if (drop_count !== 16'(m_drop) || overflow !== m_ovf || protocol_err !== m_perr) begin errors++;
        $display("FAIL rand_stats cyc %0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, drop_count, overflow,
                 protocol_err, m_drop, m_ovf, m_perr); end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_single_reg();
    test_dual_push();
    test_filtered();
    test_overflow();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
